conv_exec_array: RTL
====================

CONV_EXEC_ARRAY -- requirements
Module: conv_exec_array

Interface
REQ-001 Parameter CH, default 6: number of parallel channels, range 1..16.
REQ-002 Parameter DIN_W, default 23: signed MAC input width per channel.
REQ-003 Parameter DOUT_W, default 16: signed output width per channel.
REQ-004 Parameter SHIFT, default 7: arithmetic right shift applied to each MAC value before bias add, range 0..DIN_W-2.
REQ-005 Ports are fixed as follows; one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts the input vector this cycle.
- d_in  in  CH*DIN_W  packed signed MAC values; channel k at bits [k*DIN_W +: DIN_W].
- relu_en  in  1  1 = clamp negatives to 0; sampled with the input vector.
- bias_wr_en  in  1  bias write strobe.
- bias_wr_idx  in  4  channel index for the bias write.
- bias_wr_data  in  DOUT_W  signed bias value.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output.
- d_out  out  CH*DOUT_W  packed signed results, same packing as d_in.
- sat_cnt  out  16  saturation event count.

Function
REQ-006 Transfers occur on in_valid&in_ready at the input and on out_valid&out_ready at the output.
REQ-007 The pipeline has two stages (S1, S2), each with its own valid bit; the latency from input transfer to out_valid is 2 cycles when there is no stall.
REQ-008 Stage enables: en2 = ~s2_valid | out_ready; en1 = ~s1_valid | en2; in_ready = en1. in_ready depends combinationally only on valid bits and out_ready.
REQ-009 S1 stores, per channel, sum = (d_in_k >>> SHIFT) + sign-extended bias_k, computed at DIN_W+1 bits with no overflow. It also stores relu_en.
REQ-010 S2 stores each saturated lane result:
- sum > 2^(DOUT_W-1)-1 gives the maximum value;
- sum < -2^(DOUT_W-1) gives the minimum value;
- otherwise the low DOUT_W bits of sum.
After saturation, if the stored relu_en=1, negative results become 0.
REQ-011 While out_valid=1 and out_ready=0, d_out and out_valid stay stable; no data is lost or duplicated.
REQ-012 Bias registers: there are CH registers of DOUT_W bits each.
- A write to idx<CH updates that register at the clock edge.
- A write to idx>=CH is ignored.
- Writes are accepted in any cycle, including during a stall.
REQ-013 If a bias write and an input transfer happen in the same cycle, S1 uses the old bias; the new bias applies from the next transfer onward.
REQ-014 An input vector held in S1 during a stall keeps its already-computed sum; later bias writes do not affect it.
REQ-015 d_out shows the S2 register contents at all times; its value is don't-care when out_valid=0.

Reset
REQ-016 While rst_n=0 at a clock edge, the following are cleared: s1_valid, s2_valid, all bias registers, d_out, and sat_cnt.
REQ-017 Reset taken mid-operation discards in-flight vectors without emitting them; out_valid=0 and in_ready=1 on the first cycle after reset is released.

Configuration
REQ-018 The macro CONV_EXEC_SATCNT_EN controls saturation counting.
- Defined: sat_cnt increments by 1 on each S2 load in which any lane saturated (before ReLU), and holds at 16'hFFFF.
- Not defined: the counter is not built and sat_cnt is tied to 0.

Structure
REQ-019 Package conv_pkg holds default constants: CH_DEF, DIN_W_DEF, DOUT_W_DEF, SHIFT_DEF, and the 4-bit bias index width.
REQ-020 A single sub-module, conv_exec_lane, implements the per-channel shift, bias add and saturate/ReLU datapath with its S1/S2 data registers. It is instantiated CH times by generate. Valid and handshake control stays in the top module.

Verification
REQ-021 All cases below use default parameters.
- Basic add: bias[0]=5 written, relu_en=1, d_in ch0 = 12800 -> ch0 out = 105, 2 cycles after acceptance.
- ReLU: bias[1]=3, ch1 = -1280 with relu_en=1 -> 0; same input with relu_en=0 -> 16'hFFF9.
- Positive saturation: bias[2]=100, ch2 = 4194303 -> 16'h7FFF. Negative saturation: bias[2]=-1, ch2 = -4194304, relu_en=0 -> 16'h8000. With CONV_EXEC_SATCNT_EN defined, sat_cnt = 2.
- Backpressure: continuous in_valid with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, d_out holds. After out_ready returns to 1, all vectors appear in order with none lost.
- Bias timing: bias_wr_en with an input transfer in the same cycle -> the result uses the old bias; the next vector uses the new bias. A write with bias_wr_idx=6 leaves all biases unchanged.
- Reset: rst_n=0 while both stages are full -> next cycle out_valid=0, in_ready=1, all biases 0, sat_cnt=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults for the convolution execution array.
// Holds the parameter defaults used by conv_exec_array and conv_exec_lane,
// and the width of the bias register index.
package conv_pkg;

  localparam int CH_DEF     = 6;
  localparam int DIN_W_DEF  = 23;
  localparam int DOUT_W_DEF = 16;
  localparam int SHIFT_DEF  = 7;
  localparam int BIAS_IDX_W = 4;

  typedef logic [BIAS_IDX_W-1:0] bias_idx_t;

endpackage

// File: rtl/conv_exec_lane.sv
// One channel of the execution array.
// S1 holds (d_in >>> SHIFT) + bias at DIN_W+1 bits, so the add cannot overflow.
// S2 holds that sum saturated to DOUT_W bits, then optionally clamped by ReLU.
// The stage enables and the stored relu flag come from the top module, which
// owns all valid/handshake state.
module conv_exec_lane
  import conv_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en1,
  input  logic              en2,
  input  logic              relu_s1,
  input  logic [DIN_W-1:0]  d_in,
  input  logic [DOUT_W-1:0] bias,
  output logic [DOUT_W-1:0] d_out,
  output logic              sat
);

  logic signed [DIN_W:0]    d_ext;
  logic signed [DIN_W:0]    shifted;
  logic signed [DIN_W:0]    bias_ext;
  logic signed [DIN_W:0]    sum_next;
  logic signed [DIN_W:0]    sum_reg;
  logic [DIN_W-DOUT_W+1:0]  top_bits;
  logic [DOUT_W-1:0]        sat_val;
  logic [DOUT_W-1:0]        clip_val;
  logic [DOUT_W-1:0]        res_next;
  logic [DOUT_W-1:0]        d_out_reg;

  assign d_ext    = $signed({d_in[DIN_W-1], d_in});
  assign shifted  = d_ext >>> SHIFT;
  assign bias_ext = $signed({{(DIN_W+1-DOUT_W){bias[DOUT_W-1]}}, bias});
  assign sum_next = shifted + bias_ext;

  // The sum fits DOUT_W bits exactly when every bit from the DOUT_W sign
  // position upward agrees; otherwise clamp toward the sign of the sum.
  assign top_bits = sum_reg[DIN_W:DOUT_W-1];
  assign sat      = ~((&top_bits) | ~(|top_bits));
  assign sat_val  = sum_reg[DIN_W] ? {1'b1, {(DOUT_W-1){1'b0}}}
                                   : {1'b0, {(DOUT_W-1){1'b1}}};
  assign clip_val = sat ? sat_val : sum_reg[DOUT_W-1:0];
  assign res_next = (relu_s1 && clip_val[DOUT_W-1]) ? '0 : clip_val;

  // S1: capture shifted input plus bias; held unchanged while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else if (en1) begin
      sum_reg <= sum_next;
    end
  end

  // S2: capture the saturated / ReLU result; this register drives d_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_out_reg <= '0;
    end else if (en2) begin
      d_out_reg <= res_next;
    end
  end

  assign d_out = d_out_reg;

endmodule

// File: rtl/conv_exec_array.sv
// Two-stage, CH-wide shift / bias-add / saturate / ReLU execution array with
// valid-ready handshakes on both sides and a writable per-channel bias bank.
// Optional macro CONV_EXEC_SATCNT_EN builds a saturating count of S2 loads in
// which any lane saturated; without it sat_cnt is tied to zero.
module conv_exec_array
  import conv_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DIN_W-1:0]    d_in,
  input  logic                   relu_en,
  input  logic                   bias_wr_en,
  input  logic [BIAS_IDX_W-1:0]  bias_wr_idx,
  input  logic [DOUT_W-1:0]      bias_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*DOUT_W-1:0]   d_out,
  output logic [15:0]            sat_cnt
);

  logic              s1_valid_reg;
  logic              s2_valid_reg;
  logic              relu_s1_reg;
  logic              en1;
  logic              en2;
  logic [CH-1:0]     sat_vec;
  logic [DOUT_W-1:0] bias_reg [CH];

  // A stage may load when it is empty or when the stage after it moves on.
  assign en2       = ~s2_valid_reg | out_ready;
  assign en1       = ~s1_valid_reg | en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid_reg;

  // Valid bits advance with the stage enables; relu_en travels with S1 data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      relu_s1_reg  <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid_reg <= in_valid;
        relu_s1_reg  <= relu_en;
      end
      if (en2) begin
        s2_valid_reg <= s1_valid_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
      // Bias bank entry; out-of-range indices match no entry and are dropped.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          bias_reg[gi] <= '0;
        end else if (bias_wr_en && (bias_wr_idx == BIAS_IDX_W'(gi))) begin
          bias_reg[gi] <= bias_wr_data;
        end
      end

      conv_exec_lane #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W),
        .SHIFT  (SHIFT)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .en1     (en1),
        .en2     (en2),
        .relu_s1 (relu_s1_reg),
        .d_in    (d_in[gi*DIN_W +: DIN_W]),
        .bias    (bias_reg[gi]),
        .d_out   (d_out[gi*DOUT_W +: DOUT_W]),
        .sat     (sat_vec[gi])
      );
    end
  endgenerate

`ifdef CONV_EXEC_SATCNT_EN
  logic [15:0] sat_cnt_reg;

  // Count S2 loads of a valid vector with any saturated lane; stick at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_reg <= '0;
    end else if (en2 && s1_valid_reg && (|sat_vec) && (sat_cnt_reg != 16'hFFFF)) begin
      sat_cnt_reg <= sat_cnt_reg + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_reg;
`else
  logic unused_sat;
  assign unused_sat = ^sat_vec;
  assign sat_cnt    = '0;
`endif

endmodule
